// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for a dual-issue pipeline.
// One FSM drives a shared multiplier and a 32-step restoring divider.
// A one-entry pending buffer holds the younger request when both slots
// issue together. The DONE cycle of a job doubles as the first working
// cycle of the pending job, so back-to-back latency counts from that edge.
module md_sched #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0_valid,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        flush,
    output logic        stall_o,
    output logic [1:0]  whilo,
    output logic [63:0] hilo_out,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    localparam logic [5:0] MulLast = 6'(MUL_LAT - 1);
    localparam logic [5:0] DivLast = 6'd31;

    state_e      state_q, state_d;

    // Active job: op and operands as accepted
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;

    // One-entry pending buffer for the younger slot
    logic        pend_valid_q;
    logic [1:0]  pend_op_q;
    logic [31:0] pend_a_q, pend_b_q;

    // Shared counter: multiply latency or divide iteration index
    logic [5:0]  cnt_q;
    // Set when a divide was launched from IDLE and still needs its magnitude step
    logic        div_prep_q;

    // Divider working registers
    logic [31:0] rem_q, quo_q, dvs_q;

    logic [63:0] result_q;

    // Request selection
    logic        any_req;
    logic        launch;
    logic [1:0]  launch_op;
    logic [31:0] launch_a, launch_b;

    // Job activity decode
    logic        pend_run;
    logic        run_mul, run_div_prep, run_div_iter;
    logic        mul_last, div_last;
    logic        done_entry;
    logic        capture;

    // Multiplier
    logic        mul_signed;
    logic [63:0] mul_a, mul_b, product;

    // Divider
    logic        div_signed, div_by_zero, neg_quo, neg_rem;
    logic [31:0] mag_a, mag_b;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] sub;
    logic [31:0] rem_nxt, quo_nxt;
    logic [31:0] rem_fix, quo_fix;

    // Pick the request to accept in IDLE; slot 0 wins when both are valid
    always_comb begin
        any_req   = req0_valid | req1_valid;
        launch    = (state_q == StIdle) && any_req && !flush;
        launch_op = req0_valid ? req0_op : req1_op;
        launch_a  = req0_valid ? req0_a  : req1_a;
        launch_b  = req0_valid ? req0_b  : req1_b;
    end

    // Decode which datapath step runs this cycle
    always_comb begin
        // DONE with a held request: the pending job is already in op_q/a_q/b_q
        pend_run     = (state_q == StDone) && pend_valid_q;
        run_mul      = (state_q == StMul) || (pend_run && !op_q[1]);
        run_div_prep = ((state_q == StDiv) && div_prep_q) || (pend_run && op_q[1]);
        run_div_iter = (state_q == StDiv) && !div_prep_q;
        mul_last     = run_mul && (cnt_q == MulLast);
        div_last     = run_div_iter && (cnt_q == DivLast);
        done_entry   = ((state_q == StMul) || (state_q == StDiv)) && (state_d == StDone);
        capture      = (state_d == StDone);
    end

    // Single multiplier: sign-extend for MULT, zero-extend for MULTU
    always_comb begin
        mul_signed = !op_q[0];
        mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
        mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
        product    = mul_a * mul_b;
    end

    // Restoring divider step, magnitudes and final sign fix
    always_comb begin
        div_signed  = !op_q[0];
        div_by_zero = (b_q == 32'd0);
        neg_quo     = div_signed && (a_q[31] ^ b_q[31]);
        neg_rem     = div_signed && a_q[31];
        mag_a       = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
        mag_b       = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;

        shifted = {rem_q, quo_q[31]};
        fits    = shifted >= {1'b0, dvs_q};
        // Only the low 32 bits matter: when fits, the true difference is below dvs_q
        sub     = shifted[31:0] - dvs_q;
        rem_nxt = fits ? sub : shifted[31:0];
        quo_nxt = {quo_q[30:0], fits};

        if (div_by_zero) begin
            quo_fix = 32'hFFFF_FFFF;
            rem_fix = a_q;
        end else begin
            quo_fix = neg_quo ? (32'd0 - quo_nxt) : quo_nxt;
            rem_fix = neg_rem ? (32'd0 - rem_nxt) : rem_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = launch_op[1] ? StDiv : StMul;
                end
            end
            StMul: begin
                if (mul_last) begin
                    state_d = StDone;
                end
            end
            StDiv: begin
                if (div_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!pend_valid_q) begin
                    state_d = StIdle;
                end else if (op_q[1]) begin
                    state_d = StDiv;
                end else if (mul_last) begin
                    state_d = StDone;
                end else begin
                    state_d = StMul;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    // FSM outputs
    always_comb begin
        whilo    = ((state_q == StDone) && !flush) ? 2'b11 : 2'b00;
        stall_o  = ((state_q == StIdle) && any_req) ||
                   (state_q == StMul) || (state_q == StDiv) ||
                   ((state_q == StDone) && pend_valid_q);
        busy     = (state_q != StIdle) || pend_valid_q;
        hilo_out = result_q;
    end

    // Datapath: operand latches, pending buffer, counter, divider, result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q         <= 2'b00;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            pend_valid_q <= 1'b0;
            pend_op_q    <= 2'b00;
            pend_a_q     <= 32'd0;
            pend_b_q     <= 32'd0;
            cnt_q        <= 6'd0;
            div_prep_q   <= 1'b0;
            rem_q        <= 32'd0;
            quo_q        <= 32'd0;
            dvs_q        <= 32'd0;
            result_q     <= 64'd0;
        end else if (flush) begin
            pend_valid_q <= 1'b0;
            cnt_q        <= 6'd0;
            div_prep_q   <= 1'b0;
        end else begin
            if (launch) begin
                op_q       <= launch_op;
                a_q        <= launch_a;
                b_q        <= launch_b;
                cnt_q      <= 6'd0;
                div_prep_q <= launch_op[1];
            end
            if (launch && req0_valid && req1_valid) begin
                pend_valid_q <= 1'b1;
                pend_op_q    <= req1_op;
                pend_a_q     <= req1_a;
                pend_b_q     <= req1_b;
            end
            if (run_mul) begin
                cnt_q <= cnt_q + 6'd1;
            end
            if (run_div_prep) begin
                rem_q      <= 32'd0;
                quo_q      <= mag_a;
                dvs_q      <= mag_b;
                div_prep_q <= 1'b0;
                cnt_q      <= 6'd0;
            end
            if (run_div_iter) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                cnt_q <= cnt_q + 6'd1;
            end
            if (capture) begin
                result_q <= op_q[1] ? {rem_fix, quo_fix} : product;
            end
            // Result is captured at this edge, so the operand latches are free for the pending job
            if (done_entry && pend_valid_q) begin
                op_q       <= pend_op_q;
                a_q        <= pend_a_q;
                b_q        <= pend_b_q;
                cnt_q      <= 6'd0;
                div_prep_q <= 1'b0;
            end
            if (state_q == StDone) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

endmodule
